// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult
// Description : Iterative radix-2 Booth signed multiplier. One add/sub/shift
//               datapath is reused for WIDTH steps. Operands are accepted on a
//               valid/ready handshake, and the 2*WIDTH-bit product is held
//               until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int            CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // The accumulator and multiplicand are one bit wider than the operands, so
    // that subtracting the most-negative multiplicand cannot overflow.
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [WIDTH:0]     r_m;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_a_next;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_last;
    logic               w_accept;

    // Booth step selection: recode {Q[0], q_1} into add, subtract or pass
    always_comb begin
        w_t = r_a;
        unique case ({r_q[0], r_q1})
            2'b10:   w_t = r_a - r_m;
            2'b01:   w_t = r_a + r_m;
            default: w_t = r_a;
        endcase
    end

    // Arithmetic right shift of the combined {T, Q, q_1} register
    assign w_a_next = {w_t[WIDTH], w_t[WIDTH:1]};
    assign w_q_next = {w_t[0], r_q[WIDTH-1:1]};
    assign w_last   = (r_cnt == C_LAST);
    assign w_accept = in_valid && (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: load operands on accept, one Booth step per RUN cycle, and
    // capture the product on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_q   <= a;
            r_q1  <= 1'b0;
            r_m   <= {b[WIDTH-1], b};
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + C_ONE;
            if (w_last) begin
                r_product <= {w_a_next[WIDTH-1:0], w_q_next};
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Iterative radix-2 Booth signed multiplier controller: one add/subtract/shift datapath, reused for WIDTH cycles, replacing the fully unrolled combinational array where area matters.
- Accepts operand pairs over a valid/ready handshake, sequences the Booth steps with an FSM and step counter, and holds the 2*WIDTH-bit product until the consumer takes it.
- Sits between an operand source and a result sink on the same clock.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); also the Booth iteration count. Legal range 4..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  multiplier (signed), loaded into Q
- b  input  WIDTH  multiplicand (signed), loaded into M
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  signed product a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Asserting rst_n low at any time, including mid-RUN or in DONE, immediately forces IDLE.
- Reset values:
  - FSM = IDLE, counter = 0, product = 0, out_valid = 0, busy = 0.
  - in_ready = 1, because it is decoded from state IDLE.
  - Any operation in flight is discarded. No result is produced for it.
- Internal registers:
  - A: WIDTH+1 bits, sign-extended accumulator. The extra bit makes the most-negative multiplicand exact.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - M: WIDTH+1 bits, b sign-extended.
  - cnt: ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, busy = 0, out_valid = 0.
  - On in_valid && in_ready at an edge: A = 0, Q = a, q_1 = 0, M = sext(b), cnt = 0, go to RUN.
  - a and b are sampled only at this edge. Later changes on them are ignored.
- RUN (one Booth step per clock):
  - in_ready = 0, busy = 1.
  - Step selection on {Q[0], q_1}:
    - 00 or 11: T = A.
    - 10: T = A - M.
    - 01: T = A + M.
  - Then arithmetic right shift of {T, Q, q_1} by one: A = {T[WIDTH], T[WIDTH:1]}, Q = {T[0], Q[WIDTH-1:1]}, q_1 = Q[0].
  - All arithmetic is modulo 2^(WIDTH+1). No overflow is possible with the extra bit.
  - cnt increments each step. On the step where cnt == WIDTH-1:
    - product <= {A_next[WIDTH-1:0], Q_next}
    - go to DONE.
- DONE:
  - out_valid = 1, busy = 1, in_ready = 0.
  - product is held stable for as long as out_valid is high and out_ready is low (backpressure of any length).
  - On out_ready at an edge: go to IDLE, out_valid = 0. The product register keeps its last value.
- Latency:
  - Acceptance edge E. Steps execute at edges E+1..E+WIDTH.
  - out_valid is high from the cycle after edge E+WIDTH.
  - That is WIDTH cycles of latency from acceptance to result.
- Throughput: at most one operation per WIDTH+2 cycles. in_ready returns the cycle after the output handshake. There is no overlap of result drain and new accept.
- in_valid while busy: ignored. The source must hold the pair until in_ready (standard valid/ready; valid must not depend on ready).
- out_ready while not out_valid: ignored.
- Simultaneous rst_n low and any handshake: reset wins.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid exactly 8 cycles after the accept edge, product=16'h000F; in_ready=0 and busy=1 for those cycles.
- a=-3 (8'hFD), b=5 -> product=16'hFFF1; a=5, b=-3 -> 16'hFFF1; a=0, b=-77 -> 16'h0000.
- Boundaries:
  - a=-128, b=-128 -> 16'h4000.
  - a=127, b=-128 -> 16'hC080.
  - a=-128, b=127 -> 16'hC080.
  - a=-1, b=-1 -> 16'h0001.
- Backpressure: a=7, b=-9, out_ready held 0 for 5 cycles after out_valid -> out_valid and product=16'hFFC1 stable throughout. One cycle after out_ready=1, out_valid=0 and in_ready=1.
- New in_valid with a=1, b=1 driven during RUN, then operands changed mid-RUN -> ignored; result equals the originally accepted pair. The second pair is accepted only once in_ready=1.
- rst_n pulsed low at step 4 of a=100, b=100 -> outputs go immediately to the reset values, with no out_valid. A following a=100, b=100 run yields 16'h2710.
- Randomized check against a signed reference model: 1000 random pairs with random out_ready stalls (WIDTH=8), then a WIDTH=16 spot run.
